// File: rtl/tlc_pkg.sv
// tlc_pkg: shared types and default constants for the traffic-light
// controller's sensor conditioning logic.
//   sens_state_t : per-channel detector state (IDLE, QUAL, PRESENT, GAP)
//   *_DEF        : default parameter values for the conditioner
//   max_int      : helper used when sizing internal counters
package tlc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    PRESENT = 2'd2,
    GAP     = 2'd3
  } sens_state_t;

  localparam int SYNC_STAGES_DEF  = 2;
  localparam int DEBOUNCE_CNT_DEF = 4;
  localparam int HOLD_CNT_DEF     = 8;
  localparam int STUCK_CNT_DEF    = 1000;
  localparam int CTR_W_DEF        = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sensor_channel.sv
// sensor_channel: one vehicle-loop detector channel. Synchronises the raw
// line, debounces arrivals, gap-extends departures, flags a stuck-on
// detector and counts vehicles (saturating).
// Ports:
//   clk_i    - system clock, rising edge
//   rst_n_i  - asynchronous active-low reset
//   raw_i    - raw detector line, asynchronous to clk_i
//   clr_i    - synchronous clear of the vehicle counter (wins over increment)
//   pres_o   - conditioned presence, decoded from registered state only
//   fault_o  - detector declared stuck-on
//   cnt_o    - saturating vehicle count
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no vehicle; waiting for synchronised input high
// QUAL    | input high, counting toward the debounce threshold
// PRESENT | vehicle present, input high
// GAP     | vehicle present, input dropped; counting toward release
module sensor_channel
  import tlc_pkg::*;
#(
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
  parameter int HOLD_CNT     = HOLD_CNT_DEF,
  parameter int STUCK_CNT    = STUCK_CNT_DEF,
  parameter int CTR_W        = CTR_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             raw_i,
  input  logic             clr_i,
  output logic             pres_o,
  output logic             fault_o,
  output logic [CTR_W-1:0] cnt_o
);

  localparam int PH_W = $clog2(max_int(DEBOUNCE_CNT, HOLD_CNT)) + 1;
  localparam int ST_W = $clog2(STUCK_CNT) + 1;

  localparam logic [PH_W-1:0]  DEB_LAST  = PH_W'(DEBOUNCE_CNT - 1);
  localparam logic [PH_W-1:0]  HOLD_LAST = PH_W'(HOLD_CNT - 1);
  localparam logic [ST_W-1:0]  ST_MAX    = ST_W'(STUCK_CNT);
  localparam logic [CTR_W-1:0] CNT_MAX   = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  sens_state_t            state_q, state_d;
  logic [PH_W-1:0]        ph_q, ph_d;
  logic [ST_W-1:0]        stuck_q, stuck_d;
  logic                   fault_q, fault_d;
  logic [CTR_W-1:0]       cnt_q, cnt_d;
  logic                   arrive;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= '0;
      state_q <= IDLE;
      ph_q    <= '0;
      stuck_q <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      state_q <= state_d;
      ph_q    <= ph_d;
      stuck_q <= stuck_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    arrive  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = QUAL;
          ph_d    = PH_W'(1);
        end
      end
      QUAL: begin
        if (!s) begin
          state_d = IDLE;
        end else if (ph_q == DEB_LAST) begin
          state_d = PRESENT;
          arrive  = 1'b1;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      PRESENT: begin
        if (!s) begin
          state_d = GAP;
          ph_d    = PH_W'(1);
        end
      end
      GAP: begin
        // Returning to PRESENT from GAP is the same vehicle: no arrive pulse.
        if (s) begin
          state_d = PRESENT;
        end else if (ph_q == HOLD_LAST) begin
          state_d = IDLE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stuck counter saturates at its threshold so a permanently stuck loop
  // cannot wrap it and momentarily un-fault the channel.
  always_comb begin
    stuck_d = '0;
    if (state_q == PRESENT && s) begin
      stuck_d = (stuck_q == ST_MAX) ? stuck_q : stuck_q + ST_W'(1);
    end
  end

  // Fault is sticky and only released on the edge the FSM re-enters IDLE.
  always_comb begin
    fault_d = fault_q | (stuck_d == ST_MAX);
    if (state_d == IDLE) begin
      fault_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (arrive && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CTR_W'(1);
    end
  end

  assign pres_o  = (state_q == PRESENT || state_q == GAP) && !fault_q;
  assign fault_o = fault_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner: two independent detector channels producing
// the clean Ta/Tb presence levels for the traffic-light FSM, stuck-detector
// flags and saturating per-approach vehicle counts.
// Ports:
//   CLK            - system clock, rising edge
//   RST_N          - asynchronous active-low reset
//   SA_RAW, SB_RAW - raw detector lines for approaches A and B (async)
//   CLR            - synchronous clear of both vehicle counters
//   Ta, Tb         - conditioned presence per approach
//   FAULT_A/B      - detector stuck-on flags
//   CNT_A/B        - saturating vehicle counts
module traffic_sensor_conditioner
  import tlc_pkg::*;
#(
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
  parameter int HOLD_CNT     = HOLD_CNT_DEF,
  parameter int STUCK_CNT    = STUCK_CNT_DEF,
  parameter int CTR_W        = CTR_W_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SA_RAW,
  input  logic             SB_RAW,
  input  logic             CLR,
  output logic             Ta,
  output logic             Tb,
  output logic             FAULT_A,
  output logic             FAULT_B,
  output logic [CTR_W-1:0] CNT_A,
  output logic [CTR_W-1:0] CNT_B
);

  sensor_channel #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .HOLD_CNT     (HOLD_CNT),
    .STUCK_CNT    (STUCK_CNT),
    .CTR_W        (CTR_W)
  ) u_chan_a (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .raw_i   (SA_RAW),
    .clr_i   (CLR),
    .pres_o  (Ta),
    .fault_o (FAULT_A),
    .cnt_o   (CNT_A)
  );

  sensor_channel #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .HOLD_CNT     (HOLD_CNT),
    .STUCK_CNT    (STUCK_CNT),
    .CTR_W        (CTR_W)
  ) u_chan_b (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .raw_i   (SB_RAW),
    .clr_i   (CLR),
    .pres_o  (Tb),
    .fault_o (FAULT_B),
    .cnt_o   (CNT_B)
  );

endmodule

// File: doc/traffic_sensor_conditioner.md
# traffic_sensor_conditioner

Two-channel input conditioner for the intersection's vehicle loop detectors. It synchronises, debounces and gap-extends the raw detector lines and produces the clean `Ta`/`Tb` presence levels consumed by the traffic-light FSM. It also flags stuck-on detectors and forces them inactive so one approach cannot starve the other. It keeps saturating per-approach vehicle counts for maintenance readout.

## Interface
- `SYNC_STAGES`, 2 — synchroniser depth on each raw input (≥2)
- `DEBOUNCE_CNT`, 4 — consecutive synchronised-high cycles required to declare presence (≥2)
- `HOLD_CNT`, 8 — consecutive synchronised-low cycles before presence is released (≥2)
- `STUCK_CNT`, 1000 — continuous high cycles in PRESENT before a channel is declared stuck (≥2)
- `CTR_W`, 8 — vehicle counter width
- `CLK` in 1 — single clock, all logic on rising edge
- `RST_N` in 1 — asynchronous, active-low reset
- `SA_RAW` in 1 — raw detector, approach A, asynchronous to `CLK`
- `SB_RAW` in 1 — raw detector, approach B, asynchronous
- `CLR` in 1 — synchronous clear of both vehicle counters
- `Ta` out 1 — conditioned presence, approach A
- `Tb` out 1 — conditioned presence, approach B
- `FAULT_A` out 1 — approach A detector stuck
- `FAULT_B` out 1 — approach B detector stuck
- `CNT_A` out CTR_W — vehicles detected on A, saturating
- `CNT_B` out CTR_W — vehicles detected on B, saturating

## Operation
- Each channel is independent and identical. `s` is the synchronised input (last synchroniser flop).
- Per-channel FSM states are IDLE, QUAL, PRESENT and GAP. Each channel has a phase counter `cnt`.
  - IDLE: `s`=1 → QUAL, `cnt`←1. Otherwise stay.
  - QUAL: `s`=0 → IDLE. `s`=1 and `cnt`==DEBOUNCE_CNT−1 → PRESENT. Otherwise `cnt`++.
  - PRESENT: `s`=0 → GAP, `cnt`←1. Otherwise stay.
  - GAP: `s`=1 → PRESENT; the vehicle is not re-counted. `s`=0 and `cnt`==HOLD_CNT−1 → IDLE. Otherwise `cnt`++.
- Presence output is `Tx` = (state ∈ {PRESENT, GAP}) ∧ ¬fault. It is decoded from registered state only, with no raw-input path.
- Stuck detection:
  - A stuck counter increments each cycle the channel is in PRESENT with `s`=1. It clears on any other cycle.
  - When the stuck counter reaches STUCK_CNT, fault sets.
  - Fault is sticky until the FSM returns to IDLE. It clears on the same edge the FSM enters IDLE.
- Vehicle counters:
  - A counter increments by 1 on the QUAL→PRESENT transition only.
  - It saturates at 2^CTR_W−1 and does not wrap.
  - `CLR` takes priority over an increment on the same edge; the result is 0.
- Reset (`RST_N`=0, asynchronous):
  - Synchronisers go to 0, FSMs to IDLE, and all counters to 0.
  - `Ta`=`Tb`=0, `FAULT_A`=`FAULT_B`=0, `CNT_A`=`CNT_B`=0.
  - Reset asserted mid-qualification or mid-gap discards that progress immediately.
  - Release is synchronous-safe: no state changes on the first edge after deassertion unless `s` is already 1 at that edge. `s` is 0 out of reset.

## Timing
- Rise latency: `Tx` goes high SYNC_STAGES+DEBOUNCE_CNT edges after the first edge that samples raw high. With defaults this is after edge 6.
- Fall latency: `Tx` goes low SYNC_STAGES+HOLD_CNT edges after the first edge that samples raw low. With defaults this is after edge 10.
- A raw pulse shorter than DEBOUNCE_CNT cycles (after synchronisation) never asserts `Tx`. It also does not increment the counter.
- A raw drop shorter than HOLD_CNT cycles during presence keeps `Tx` high continuously.
- Fault: `FAULT_x` rises and `Tx` falls on the same edge, STUCK_CNT cycles after PRESENT is entered with input held high.
- The count update is visible the cycle `Tx` first rises.
- Simultaneous events on A and B are fully independent; both may update in the same cycle.

## Structure
- Shared package `tlc_pkg`:
  - State enum `sens_state_t` (IDLE=0, QUAL=1, PRESENT=2, GAP=3).
  - Default parameter constants.
- One sub-module, `sensor_channel`, is instantiated twice. It holds the synchroniser, FSM, phase counter, stuck counter, fault flag and vehicle counter.
- The top level is wiring only.
- Internal counter widths are sized with `$clog2` of the largest compare value plus 1.

## Test plan
- Reset: hold `RST_N`=0 with raw inputs toggling → all outputs 0. Deassert with raw=0 → outputs stay 0 for 20 cycles.
- Clean arrival (defaults): `SA_RAW` high from edge 1 → `Ta` high after edge 6 and `CNT_A`=1. Drop raw at edge 30 → `Ta` low after edge 39. `Tb` stays 0 throughout.
- Glitch rejection: `SB_RAW` high for 2 cycles, low 10, high 3 → `Tb` never asserts and `CNT_B`=0. Then a 6-cycle gap inside a long presence → `Tb` stays high and `CNT_B` increments once only.
- Stuck detector: `SA_RAW` held high with STUCK_CNT=20 → `Ta` high for 20 cycles, then `FAULT_A`=1 and `Ta`=0. Release raw → `FAULT_A` clears on the edge the FSM re-enters IDLE.
- Saturation and clear: CTR_W=3 with 9 clean arrivals on B → `CNT_B`=7. Assert `CLR` on the edge of a 10th arrival → `CNT_B`=0.
- Reset mid-operation: assert `RST_N` low while A is in GAP and B is in QUAL → immediate zero outputs. After release with both raws high, full rise latency is required again.
